// File: rtl/ab_sequencer_arbiter_if.sv
// ---------------------------------------------------------------------------
// ab_sequencer_arbiter_if
//   Groups the requester-side and checker-side signals of ab_sequencer_arbiter.
//
//   Requester side : req (level, in), grant (one-hot owner, out),
//                    ack (one-cycle completion pulse, out),
//                    resp_code (00 ok / 01 checker error / 10 timeout, out).
//   Checker side   : a_out, b_out (strobes, out), clr_out (sync clear, out),
//                    done_in, error_in (checker status, in).
//
//   Handshake: a requester holds req high until it sees its ack bit. The
//   arbiter answers every granted transaction with exactly one ack pulse,
//   and resp_code is meaningful only in that ack cycle. Dropping req after
//   grant does not cancel the transaction.
//
//   Modports: master = arbiter view, slave = requester/checker view.
// ---------------------------------------------------------------------------
interface ab_sequencer_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ack;
  logic [1:0]      resp_code;
  logic            a_out;
  logic            b_out;
  logic            clr_out;
  logic            done_in;
  logic            error_in;

  modport master (
    input  req, done_in, error_in,
    output grant, ack, resp_code, a_out, b_out, clr_out
  );

  modport slave (
    output req, done_in, error_in,
    input  grant, ack, resp_code, a_out, b_out, clr_out
  );
endinterface

// File: rtl/ab_sequencer_arbiter.sv
// ---------------------------------------------------------------------------
// ab_sequencer_arbiter
//   Shares one A/B handshake checker between NREQ requesters with round-robin
//   arbitration. Each transaction: A strobe, B strobe, wait for done/error
//   (bounded by TIMEOUT cycles), clear the checker and ack the owner.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous active-low reset
//     bus        ab_sequencer_arbiter_if.master (req/grant/ack/resp_code,
//                a_out/b_out/clr_out, done_in/error_in)
//     busy       high in any state except IDLE
//     state_out  current FSM state encoding (debug)
//
//   All outputs are decoded from registered state only (Moore).
// ---------------------------------------------------------------------------
module ab_sequencer_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  ab_sequencer_arbiter_if.master bus,
  output logic                  busy,
  output logic [2:0]            state_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT   = 3'd3,
    CLEAR  = 3'd4
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   rr_ptr, rr_d;
  logic [PW-1:0]   owner, owner_d;
  logic [TW-1:0]   timer, timer_d;
  logic [1:0]      code, code_d;

  logic            sel_found;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   idx;
  logic [NREQ-1:0] owner_hot;

  // Round-robin pick: first set req bit at or above rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NREQ);
      if (!sel_found && bus.req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      timer  <= '0;
      code   <= 2'b00;
    end else begin
      state  <= state_d;
      rr_ptr <= rr_d;
      owner  <= owner_d;
      timer  <= timer_d;
      code   <= code_d;
    end
  end

  always_comb begin
    state_d = state;
    rr_d    = rr_ptr;
    owner_d = owner;
    timer_d = timer;
    code_d  = code;
    case (state)
      IDLE: begin
        if (sel_found) begin
          owner_d = sel_idx;
          state_d = SEND_A;
        end
      end
      SEND_A: state_d = SEND_B;
      SEND_B: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // error outranks done when both arrive together
        if (bus.error_in) begin
          code_d  = 2'b01;
          state_d = CLEAR;
        end else if (bus.done_in) begin
          code_d  = 2'b00;
          state_d = CLEAR;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          code_d  = 2'b10;
          state_d = CLEAR;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      CLEAR: begin
        state_d = IDLE;
        rr_d    = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign owner_hot     = NREQ'(1) << owner;
  assign bus.grant     = (state inside {SEND_A, SEND_B, WAIT, CLEAR}) ? owner_hot : '0;
  assign bus.ack       = (state == CLEAR) ? owner_hot : '0;
  assign bus.resp_code = (state == CLEAR) ? code : 2'b00;
  assign bus.a_out     = (state == SEND_A);
  assign bus.b_out     = (state == SEND_B);
  assign bus.clr_out   = (state == CLEAR);
  assign busy          = (state != IDLE);
  assign state_out     = state;

endmodule
